// File: rtl/counter_pkg.sv
// ---------------------------------------------------------------------------
// counter_pkg
//   Shared constants for the up/down counter and anything that drives it.
//   The direction encoding lives here so that callers never hard-code the
//   meaning of the dir bit.
//
//   Contents:
//     DIR_UP    dir value that makes the counter increment
//     DIR_DOWN  dir value that makes the counter decrement
// ---------------------------------------------------------------------------
package counter_pkg;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage : counter_pkg

// File: rtl/counter_if.sv
// ---------------------------------------------------------------------------
// counter_if
//   Control/data bundle between a counter and whoever drives it.
//
//   Parameters:
//     N    width of the count value
//
//   Signals:
//     ce   count enable, 1 = step on the next rising edge, 0 = hold
//     dir  direction, DIR_UP (0) = increment, DIR_DOWN (1) = decrement
//     val  current count, N bits
//
//   Modports:
//     master  drives ce/dir, observes val (the controlling logic)
//     slave   observes ce/dir, drives val (the counter itself)
// ---------------------------------------------------------------------------
interface counter_if #(
    parameter int N = 8
);

    logic         ce;
    logic         dir;
    logic [N-1:0] val;

    modport master (
        output ce,
        output dir,
        input  val
    );

    modport slave (
        input  ce,
        input  dir,
        output val
    );

endinterface : counter_if

// File: rtl/counter.sv
// ---------------------------------------------------------------------------
// counter
//   N-bit synchronous up/down counter with clock enable. Each rising edge
//   with ce high moves the count one step in the direction given by dir;
//   arithmetic wraps modulo 2**N with no saturation and no flags. The output
//   comes straight from the state register, so there is no combinational
//   path from ce/dir to val.
//
//   Parameters:
//     N    counter width in bits (N >= 1), must match the interface width
//
//   Ports:
//     clk  system clock, all state changes on the rising edge
//     rst  synchronous active-high reset, clears the count (beats ce/dir)
//     bus  counter_if slave: ce, dir in; val out
// ---------------------------------------------------------------------------
module counter
    import counter_pkg::*;
#(
    parameter int N = 8
) (
    input logic      clk,
    input logic      rst,
    counter_if.slave bus
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    // Power-up value of zero keeps val defined before rst is ever asserted.
    logic [N-1:0] count = '0;
    logic [N-1:0] next;

    // Next-value mux: hold when disabled, otherwise one step up or down.
    // Plain N-bit add/subtract gives the modulo-2**N wrap for free.
    always_comb begin
        next = count;
        if (bus.ce) begin
            if (bus.dir == DIR_DOWN) begin
                next = count - ONE;
            end else begin
                next = count + ONE;
            end
        end
    end

    // State register; reset has priority over any step request.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= next;
        end
    end

    assign bus.val = count;

endmodule : counter

// File: tb/tb_counter.sv
// ---------------------------------------------------------------------------
// tb_counter
//   Drives an 8-bit and a 3-bit counter with identical rst/ce/dir streams and
//   compares both against an arithmetic reference model (count mod 2**N).
//   Directed steps cover idle, increment, decrement, wrap, reset priority and
//   the narrow-width roll-over; a randomized phase follows.
// ---------------------------------------------------------------------------
module tb_counter;
    import counter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int checkCount = 0;
    int passCount  = 0;

    // Reference model state: plain integers reduced modulo 2**N.
    int ref8 = 0;
    int ref3 = 0;

    counter_if #(.N(8)) bus8 ();
    counter_if #(.N(3)) bus3 ();

    counter #(.N(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8.slave)
    );

    counter #(.N(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3.slave)
    );

    always #5 clk = ~clk;

    // Arithmetic model of one rising edge for a counter of modulus m.
    function automatic int modelStep(input int cur, input int m,
                                     input logic r, input logic c,
                                     input logic d);
        int stepVal;
        if (r) return 0;
        if (!c) return cur;
        stepVal = d ? -1 : 1;
        return ((cur + stepVal) % m + m) % m;
    endfunction

    // Called at a falling edge: set inputs, let one rising edge happen,
    // advance the model, and return at the following falling edge.
    task automatic applyStimulus(input logic r, input logic c, input logic d);
        rst      = r;
        bus8.ce  = c;
        bus8.dir = d;
        bus3.ce  = c;
        bus3.dir = d;
        @(posedge clk);
        ref8 = modelStep(ref8, 256, r, c, d);
        ref3 = modelStep(ref3, 8, r, c, d);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag);
        checkCount = checkCount + 1;
        assert (bus8.val === 8'(ref8)) passCount = passCount + 1;
        else $error("[TB] FAIL %s (N=8): val=%0h expected=%0h", tag, bus8.val, 8'(ref8));
        checkCount = checkCount + 1;
        assert (bus3.val === 3'(ref3)) passCount = passCount + 1;
        else $error("[TB] FAIL %s (N=3): val=%0h expected=%0h", tag, bus3.val, 3'(ref3));
    endtask

    initial begin
        bus8.ce  = 1'b0;
        bus8.dir = DIR_UP;
        bus3.ce  = 1'b0;
        bus3.dir = DIR_UP;

        // Power-up value before any reset, and across an idle edge.
        #1;
        checkOutput("powerup");
        @(negedge clk);
        checkOutput("powerup_idle");

        // Idle: reset pulse then four disabled edges.
        applyStimulus(1'b1, 1'b0, DIR_UP);
        checkOutput("reset");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, DIR_UP);
            checkOutput("idle");
        end

        // Increment on two separated single edges.
        applyStimulus(1'b0, 1'b1, DIR_UP);
        checkOutput("inc_1");
        applyStimulus(1'b0, 1'b0, DIR_DOWN);
        checkOutput("inc_hold");
        applyStimulus(1'b0, 1'b1, DIR_UP);
        checkOutput("inc_2");

        // Decrement back to zero, then hold.
        applyStimulus(1'b0, 1'b1, DIR_DOWN);
        checkOutput("dec_1");
        applyStimulus(1'b0, 1'b1, DIR_DOWN);
        checkOutput("dec_0");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, DIR_UP);
            checkOutput("dec_hold");
        end

        // Wrap below zero and back up through zero.
        applyStimulus(1'b0, 1'b1, DIR_DOWN);
        checkOutput("wrap_down");
        applyStimulus(1'b0, 1'b1, DIR_UP);
        checkOutput("wrap_up");

        // A ce pulse that ends before the rising edge must not count.
        bus8.ce = 1'b1;
        bus3.ce = 1'b1;
        #2;
        bus8.ce = 1'b0;
        bus3.ce = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("glitch");

        // Reset priority over an enabled up step, then resume from zero.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b1, DIR_UP);
        end
        checkOutput("pre_reset_5");
        applyStimulus(1'b1, 1'b1, DIR_UP);
        checkOutput("reset_priority");
        applyStimulus(1'b0, 1'b1, DIR_UP);
        checkOutput("post_reset");

        // Narrow width roll-over: nine up steps from zero.
        applyStimulus(1'b1, 1'b0, DIR_UP);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b0, 1'b1, DIR_UP);
            checkOutput("width_up");
        end

        // Randomized phase with occasional resets.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(($urandom_range(15) == 0), 1'($urandom), 1'($urandom));
            checkOutput("random");
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule : tb_counter
